sdr_16_rd_capture: RTL
======================

SDR_16_RD_CAPTURE -- requirements
Module: sdr_16_rd_capture

Interface
REQ-001 SHALL have parameter CL, default 2, meaning the SDRAM CAS latency in sdram_clk cycles; legal values are 2 and 3.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning the number of 32-bit words in the skid buffer; legal values are 2 and 4.
REQ-003 SHALL have port sdram_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port sdram_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_read, input, 1 bit: high in the cycle the upstream FSM drives a READ command, one pulse per burst-of-2.
REQ-006 SHALL have port dq_i, input, 16 bits: the SDRAM DQ pins.
REQ-007 SHALL have port fifo_full, input, 1 bit: the ingress FIFO cannot accept a word.
REQ-008 SHALL have port fifo_we, output, 1 bit: write strobe to the ingress FIFO.
REQ-009 SHALL have port fifo_dat, output, 32 bits: the assembled word {first beat, second beat}.
REQ-010 SHALL have port ovf_clr, input, 1 bit: clears ovf.
REQ-011 SHALL have port ovf, output, 1 bit: sticky flag, set when a word is dropped.
REQ-012 SHALL have port rd_busy, output, 1 bit: reads are in flight or buffered words are pending.

Function
REQ-013 SHALL delay cmd_read through a shift register of length CL (+1 with the macro, see REQ-026); the tap output marks the first beat.
- Base timing: cmd_read in cycle n; first beat sampled at the edge ending cycle n+CL; second beat at the edge ending cycle n+CL+1.
REQ-014 SHALL implement an assembly FSM with two states:
- HI: waiting for the first beat.
- LO: first beat held in the upper half.
- HI -> LO on a tagged beat.
- LO -> HI unconditionally, completing the word.
REQ-015 SHALL handle a tagged beat arriving while in LO (back-to-back reads, cmd_read every 2 cycles) with no bubble: the word completes and the next burst starts in the following cycle.
REQ-016 SHALL push a completed word into the skid buffer in the cycle after its second beat is captured.
REQ-017 SHALL derive fifo_we combinationally as (buffer non-empty AND NOT fifo_full); fifo_dat SHALL equal the buffer head.
- The buffer pops when fifo_we is high.
- Push and pop in the same cycle SHALL both occur with the count unchanged, including when the buffer is full.
REQ-018 SHALL, when a completed word finds the buffer full and no pop occurs that cycle:
- drop the word;
- set ovf;
- leave the buffer contents and order unchanged.
REQ-019 SHALL clear ovf on ovf_clr; a drop occurring in the same cycle as ovf_clr SHALL win and leave ovf set.
REQ-020 SHALL keep a 3-bit in-flight counter.
- +1 on cmd_read; -1 on word completion; both in the same cycle leaves it unchanged.
- The counter saturates at 7 and never goes below 0.
REQ-021 SHALL drive rd_busy = (in-flight counter != 0) OR (buffer non-empty).
REQ-022 SHALL make the minimum latency from cmd_read (cycle n) to fifo_we high equal cycle n+CL+2, or n+CL+3 with the macro.

Reset
REQ-023 SHALL, while sdram_rst_n is low, asynchronously clear the delay line, the FSM (to HI), the buffer pointers and count, the in-flight counter and ovf; therefore fifo_we=0, fifo_dat=0, rd_busy=0, ovf=0.
REQ-024 SHALL discard any partially assembled or in-flight data when reset is asserted mid-burst, with no fifo_we after release.
REQ-025 SHALL release reset with no additional synchronisation stage inside the block; synchronisation is provided upstream.

Configuration
REQ-026 SHALL support macro SDR_RD_CAPTURE_IOREG_EN.
- Defined: dq_i passes through one input register (an IOB flop) before assembly, and the cmd_read delay grows by one so that alignment is preserved; latency +1.
- Undefined: dq_i feeds the assembly logic directly.

Structure
REQ-027 SHALL take the FSM state encoding (HI/LO) and the CL legal-range constants from the shared package sdr_16_pkg.
REQ-028 SHALL implement the skid buffer as sub-module sdr_16_rd_skid (push, pop, full, empty, head); all other logic is flat.

Verification
REQ-029 Single read, CL=2, no macro: cmd_read at cycle 10, dq_i=16'hA5A5 at the cycle-12 edge and 16'h5A5A at the cycle-13 edge -> fifo_we in cycle 14 with fifo_dat=32'hA5A55A5A; rd_busy low from cycle 15.
REQ-030 Back-to-back: four cmd_read pulses, 2 cycles apart, CL=3, fifo_full=0 -> four consecutive-order words with no gaps other than the read spacing, and ovf=0.
REQ-031 Backpressure: fifo_full=1 throughout and three reads issued with BUF_DEPTH=2 -> two words retained, the third dropped, ovf=1; releasing fifo_full yields words 1 and 2 in order.
REQ-032 ovf_clr pulsed in the same cycle as a drop -> ovf stays 1; pulsed alone -> ovf reads 0 in the next cycle.
REQ-033 Reset asserted after the first beat of a burst -> no fifo_we after release, and rd_busy=0.
REQ-034 SDR_RD_CAPTURE_IOREG_EN defined, rerun REQ-029 -> the same data with fifo_we in cycle 15.

Source files
------------

// File: rtl/sdr_16_pkg.sv
// rtl/sdr_16_pkg.sv - shared types and constants for the SDR 16-bit read path
package sdr_16_pkg;

    typedef enum logic {
        ASM_HI = 1'b0,
        ASM_LO = 1'b1
    } asm_state_t;

    localparam int CL_MIN        = 2;
    localparam int CL_MAX        = 3;
    localparam int BUF_DEPTH_MIN = 2;
    localparam int BUF_DEPTH_MAX = 4;
    localparam int BEAT_W        = 16;
    localparam int WORD_W        = 32;
    localparam int INFLIGHT_W    = 3;

    // Out-of-range CAS latencies snap to the nearest legal value.
    function automatic int legal_cl(input int cl);
        return (cl >= CL_MAX) ? CL_MAX : CL_MIN;
    endfunction

    // Buffer depth snaps to one of the two supported power-of-two sizes.
    function automatic int legal_depth(input int depth);
        return (depth >= BUF_DEPTH_MAX) ? BUF_DEPTH_MAX : BUF_DEPTH_MIN;
    endfunction

endpackage

// File: rtl/sdr_16_rd_capture_if.sv
// rtl/sdr_16_rd_capture_if.sv - ingress FIFO write port of the read capture block
interface sdr_16_rd_capture_if;
    import sdr_16_pkg::*;

    logic              fifo_we;
    logic [WORD_W-1:0] fifo_dat;
    logic              fifo_full;

    modport master (
        output fifo_we,
        output fifo_dat,
        input  fifo_full
    );

    modport slave (
        input  fifo_we,
        input  fifo_dat,
        output fifo_full
    );

endinterface

// File: rtl/sdr_16_rd_skid.sv
// rtl/sdr_16_rd_skid.sv - small circular skid buffer for assembled read words
module sdr_16_rd_skid #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);
    assign head  = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full buffer still accepts a push alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage, pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/sdr_16_rd_capture.sv
// rtl/sdr_16_rd_capture.sv - SDRAM x16 burst-of-2 read capture into 32-bit words (option: SDR_RD_CAPTURE_IOREG_EN)
module sdr_16_rd_capture
    import sdr_16_pkg::*;
#(
    parameter int CL        = 2,
    parameter int BUF_DEPTH = 2
) (
    input  logic                 sdram_clk,
    input  logic                 sdram_rst_n,
    input  logic                 cmd_read,
    input  logic [BEAT_W-1:0]    dq_i,
    input  logic                 ovf_clr,
    output logic                 ovf,
    output logic                 rd_busy,
    sdr_16_rd_capture_if.master  fifo
);

    localparam int CL_EFF    = legal_cl(CL);
    localparam int DEPTH_EFF = legal_depth(BUF_DEPTH);
    localparam logic [INFLIGHT_W-1:0] INFLIGHT_MAX = '1;

`ifdef SDR_RD_CAPTURE_IOREG_EN
    localparam int DLY = CL_EFF + 1;

    logic [BEAT_W-1:0] dq_cap;

    // IOB-style input flop; the delay line is one stage longer to keep the tag aligned.
    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            dq_cap <= '0;
        end else begin
            dq_cap <= dq_i;
        end
    end
`else
    localparam int DLY = CL_EFF;

    logic [BEAT_W-1:0] dq_cap;

    assign dq_cap = dq_i;
`endif

    logic [DLY-1:0]        rd_dly;
    logic                  first_tag;
    asm_state_t            state;
    logic [BEAT_W-1:0]     hi_half;
    logic                  word_done;
    logic [WORD_W-1:0]     word;
    logic [INFLIGHT_W-1:0] inflight;
    logic                  buf_full;
    logic                  buf_empty;
    logic [WORD_W-1:0]     buf_head;
    logic                  pop;
    logic                  drop;

    assign first_tag = rd_dly[DLY-1];

    // The LO state is the cycle the second beat is on the bus, so the word is complete there.
    assign word_done = (state == ASM_LO);
    assign word      = {hi_half, dq_cap};

    assign pop            = !buf_empty && !fifo.fifo_full;
    assign fifo.fifo_we   = pop;
    assign fifo.fifo_dat  = buf_head;
    assign drop           = word_done && buf_full && !pop;
    assign rd_busy        = (inflight != '0) || !buf_empty;

    // Read-command delay line; the tap marks the cycle the first beat is valid.
    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            rd_dly <= '0;
        end else begin
            rd_dly <= {rd_dly[DLY-2:0], cmd_read};
        end
    end

    // Beat assembly: capture the first beat into the upper half, then always return to HI.
    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            state   <= ASM_HI;
            hi_half <= '0;
        end else begin
            case (state)
                ASM_HI: begin
                    if (first_tag) begin
                        hi_half <= dq_cap;
                        state   <= ASM_LO;
                    end
                end
                ASM_LO: begin
                    state <= ASM_HI;
                end
                default: begin
                    state <= ASM_HI;
                end
            endcase
        end
    end

    // Reads issued but not yet assembled; saturating in both directions.
    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            inflight <= '0;
        end else begin
            case ({cmd_read, word_done})
                2'b10: begin
                    if (inflight != INFLIGHT_MAX) begin
                        inflight <= inflight + 1'b1;
                    end
                end
                2'b01: begin
                    if (inflight != '0) begin
                        inflight <= inflight - 1'b1;
                    end
                end
                default: inflight <= inflight;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    sdr_16_rd_skid #(
        .DEPTH (DEPTH_EFF),
        .W     (WORD_W)
    ) u_skid (
        .clk       (sdram_clk),
        .rst_n     (sdram_rst_n),
        .push      (word_done),
        .push_data (word),
        .pop       (pop),
        .full      (buf_full),
        .empty     (buf_empty),
        .head      (buf_head)
    );

endmodule
